// File: rtl/picoblaze_sample_port_if.sv
`timescale 1ns/1ps
// PicoBlaze I/O bus bundle: port-mapped INPUT/OUTPUT cycles plus interrupt request/acknowledge.
// master = processor side, slave = peripheral side.
// Signals: port_id, read_strobe, write_strobe, out_port (cpu->periph); in_port, interrupt (periph->cpu);
//          interrupt_ack (cpu->periph).
interface picoblaze_sample_port_if;
   logic [7:0] port_id;
   logic       read_strobe;
   logic       write_strobe;
   logic [7:0] out_port;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;

   modport master (
      output port_id, read_strobe, write_strobe, out_port, interrupt_ack,
      input  in_port, interrupt
   );

   modport slave (
      input  port_id, read_strobe, write_strobe, out_port, interrupt_ack,
      output in_port, interrupt
   );
endinterface

// File: rtl/picoblaze_sample_port.sv
`timescale 1ns/1ps
// Purpose: PicoBlaze port-mapped sample FIFO (DATA/STATUS/CTRL/THRESH/PEAK at PORT_BASE+0..4) with threshold irq.
// Latency: in_port registered from port_id decode (1 clk); a DATA read pops at the read_strobe edge.
// Backpressure: sample_ready_o = !full; a sample offered while full is dropped and sets sticky overflow.
// Ports: clk, reset_n (async active-low), sample_valid_i/sample_data_i/sample_ready_o producer stream,
//        bus (picoblaze_sample_port_if.slave) for the processor I/O bus and interrupt.
// Optional: define SAMPLE_PORT_PEAK_EN to build the read-to-clear peak register at PORT_BASE+4.
module picoblaze_sample_port #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [7:0]  PORT_BASE = 8'h00
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sample_valid_i,
   input  logic [7:0]                   sample_data_i,
   output logic                         sample_ready_o,
   picoblaze_sample_port_if.slave       bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [7:0] A_DATA   = PORT_BASE;
   localparam logic [7:0] A_STATUS = PORT_BASE + 8'd1;
   localparam logic [7:0] A_CTRL   = PORT_BASE + 8'd2;
   localparam logic [7:0] A_THRESH = PORT_BASE + 8'd3;
   localparam logic [7:0] A_PEAK   = PORT_BASE + 8'd4;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          irq_en_q, irq_en_d;
   logic [7:0]    thresh_q, thresh_d;
   logic          cond_dly_q;
   logic          interrupt_q, interrupt_d;
   logic [7:0]    in_port_q, in_port_d;

   logic          empty, full, ctrl_wr, thresh_wr, flush, push, pop, ovf_evt, cond;
   logic [7:0]    thresh_eff, status, peak_rd;
   logic [8:0]    count_x;
   logic [4:0]    cnt_sat;

   assign empty          = (count_q == '0);
   assign full           = (count_q == FULL_CNT);
   assign sample_ready_o = !full;

   assign ctrl_wr   = bus.write_strobe && (bus.port_id == A_CTRL);
   assign thresh_wr = bus.write_strobe && (bus.port_id == A_THRESH);
   assign flush     = ctrl_wr && bus.out_port[1];
   // A flush discards any sample offered in the same cycle.
   assign push      = sample_valid_i && !full && !flush;
   assign pop       = bus.read_strobe && (bus.port_id == A_DATA) && !empty;
   // A drop is only an overflow when the FIFO is full; flush-discards are not drops.
   assign ovf_evt   = sample_valid_i && full;

   assign count_x    = 9'(count_q);
   assign cnt_sat    = (count_x > 9'd31) ? 5'd31 : count_x[4:0];
   assign status     = {overflow_q, full, empty, cnt_sat};
   assign thresh_eff = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
   assign cond       = irq_en_q && (count_x >= {1'b0, thresh_eff});

`ifdef SAMPLE_PORT_PEAK_EN
   logic [7:0] peak_q, peak_d;
   logic       peak_clr;

   assign peak_clr = bus.read_strobe && (bus.port_id == A_PEAK);
   assign peak_rd  = peak_q;

   always_comb begin
      peak_d = peak_q;
      if (peak_clr) begin
         // Read-to-clear; a push landing on the clearing edge seeds the next window.
         peak_d = push ? sample_data_i : 8'h00;
      end else if (push && (sample_data_i > peak_q)) begin
         peak_d = sample_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) peak_q <= 8'h00;
      else          peak_q <= peak_d;
   end
`else
   assign peak_rd = 8'h00;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are AW bits wide, so increment wraps modulo DEPTH.
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end

      overflow_d = overflow_q;
      if (ovf_evt)                         overflow_d = 1'b1;
      else if (ctrl_wr && bus.out_port[2]) overflow_d = 1'b0;

      irq_en_d = ctrl_wr   ? bus.out_port[0] : irq_en_q;
      thresh_d = thresh_wr ? bus.out_port    : thresh_q;

      // Edge-triggered request; a new rising edge beats a simultaneous ack.
      interrupt_d = interrupt_q;
      if (cond && !cond_dly_q)    interrupt_d = 1'b1;
      else if (bus.interrupt_ack) interrupt_d = 1'b0;

      in_port_d = 8'h00;
      if (bus.port_id == A_DATA)        in_port_d = empty ? 8'h00 : mem_q[rd_ptr_q];
      else if (bus.port_id == A_STATUS) in_port_d = status;
      else if (bus.port_id == A_PEAK)   in_port_d = peak_rd;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= sample_data_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         irq_en_q    <= 1'b0;
         thresh_q    <= 8'd1;
         cond_dly_q  <= 1'b0;
         interrupt_q <= 1'b0;
         in_port_q   <= 8'h00;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         irq_en_q    <= irq_en_d;
         thresh_q    <= thresh_d;
         cond_dly_q  <= cond;
         interrupt_q <= interrupt_d;
         in_port_q   <= in_port_d;
      end
   end

   assign bus.in_port   = in_port_q;
   assign bus.interrupt = interrupt_q;
endmodule

// File: tb/tb_picoblaze_sample_port.sv
`timescale 1ns/1ps
// Scoreboard bench for picoblaze_sample_port: stimulus queues expected values, a negedge monitor
// pops and compares whenever the bus shows a read strobe or the bench raises a probe.
// Default parameters (DEPTH=16, PORT_BASE=0).
module tb_picoblaze_sample_port;
   localparam logic [7:0] A_DATA = 8'h00, A_STATUS = 8'h01, A_CTRL = 8'h02, A_THRESH = 8'h03, A_PEAK = 8'h04;
   localparam int K_IN = 0, K_IRQ = 1, K_RDY = 2;
`ifdef SAMPLE_PORT_PEAK_EN
   localparam bit PEAK_ON = 1'b1;
`else
   localparam bit PEAK_ON = 1'b0;
`endif

   typedef struct {
      int         kind;
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] sample_data = 8'h00;
   logic       sample_ready;
   logic       chk_vld = 1'b0;
   logic       done = 1'b0;
   exp_t       exp_q[$];
   exp_t       cur;
   logic [7:0] act;
   int         vectors = 0;
   int         miscompares = 0;

   picoblaze_sample_port_if bus();

   picoblaze_sample_port dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sample_valid_i(sample_valid),
      .sample_data_i (sample_data),
      .sample_ready_o(sample_ready),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pk(input logic [7:0] v);
      return PEAK_ON ? v : 8'h00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input int kind, input logic [7:0] v, input string name);
      exp_t e;
      e.kind = kind;
      e.exp  = v;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic probe(input int kind, input logic [7:0] v, input string name);
      expect_val(kind, v, name);
      chk_vld = 1'b1;
      tick();
      chk_vld = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] v, input string name);
      bus.port_id = a;
      tick();
      expect_val(K_IN, v, name);
      bus.read_strobe = 1'b1;
      tick();
      bus.read_strobe = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.port_id      = a;
      bus.out_port     = d;
      bus.write_strobe = 1'b1;
      tick();
      bus.write_strobe = 1'b0;
   endtask

   task automatic flush_with_push(input logic [7:0] d);
      bus.port_id      = A_CTRL;
      bus.out_port     = 8'h02;
      bus.write_strobe = 1'b1;
      sample_valid     = 1'b1;
      sample_data      = d;
      tick();
      bus.write_strobe = 1'b0;
      sample_valid     = 1'b0;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (bus.read_strobe || chk_vld) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_check: trigger seen, required a queued expectation");
         end else begin
            cur = exp_q.pop_front();
            case (cur.kind)
               K_IRQ:   act = {7'b0, bus.interrupt};
               K_RDY:   act = {7'b0, sample_ready};
               default: act = bus.in_port;
            endcase
            if (act !== cur.exp) begin
               miscompares++;
               $display("FAIL %s: got %02h required %02h", cur.name, act, cur.exp);
            end
         end
      end
      if (done) begin
         if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: %0d checks never triggered, required 0", exp_q.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.port_id       = 8'h00;
      bus.read_strobe   = 1'b0;
      bus.write_strobe  = 1'b0;
      bus.out_port      = 8'h00;
      bus.interrupt_ack = 1'b0;

      // Reset state
      tick();
      tick();
      probe(K_IN,  8'h00, "rst_in_port");
      probe(K_IRQ, 8'h00, "rst_interrupt");
      probe(K_RDY, 8'h01, "rst_ready");
      reset_n = 1'b1;
      tick();
      rd(A_STATUS, 8'h20, "rst_status");
      rd(A_PEAK,   8'h00, "rst_peak");
      rd(8'h07,    8'h00, "unmapped");

      // Fill / drain
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      probe(K_RDY, 8'h00, "full_ready");
      rd(A_STATUS, 8'h50, "full_status");
      rd(A_CTRL,   8'h00, "ctrl_reads_zero");
      for (int i = 0; i < 16; i++) rd(A_DATA, 8'h10 + 8'(i), $sformatf("drain%0d", i));
      rd(A_STATUS, 8'h20, "drained_status");
      rd(A_DATA,   8'h00, "empty_data");
      rd(A_STATUS, 8'h20, "empty_pop_status");

      // Overflow
      for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
      rd(A_STATUS, 8'hD0, "ovf_status");
      wr(A_CTRL, 8'h04);
      rd(A_STATUS, 8'h50, "ovf_cleared");
      for (int i = 0; i < 16; i++) rd(A_DATA, 8'h40 + 8'(i), $sformatf("ovf_data%0d", i));
      rd(A_STATUS, 8'h20, "ovf_drained");

      // Interrupt
      wr(A_THRESH, 8'd4);
      wr(A_CTRL, 8'h01);
      for (int i = 1; i <= 4; i++) push(8'(i));
      probe(K_IRQ, 8'h00, "irq_not_yet");
      probe(K_IRQ, 8'h01, "irq_raised");
      bus.interrupt_ack = 1'b1;
      tick();
      bus.interrupt_ack = 1'b0;
      probe(K_IRQ, 8'h00, "irq_acked");
      push(8'h05);
      tick();
      probe(K_IRQ, 8'h00, "irq_no_reassert");
      wr(A_CTRL, 8'h02);
      rd(A_STATUS, 8'h20, "irq_flushed");

      // Simultaneous push / pop
      push(8'h61); push(8'h62); push(8'h63);
      bus.port_id = A_DATA;
      tick();
      expect_val(K_IN, 8'h61, "pp_pop");
      bus.read_strobe = 1'b1;
      sample_valid    = 1'b1;
      sample_data     = 8'hAA;
      tick();
      bus.read_strobe = 1'b0;
      sample_valid    = 1'b0;
      rd(A_STATUS, 8'h03, "pp_count");
      rd(A_DATA, 8'h62, "pp_d1");
      rd(A_DATA, 8'h63, "pp_d2");
      rd(A_DATA, 8'hAA, "pp_last");
      rd(A_STATUS, 8'h20, "pp_empty");

      // Flush keeps overflow; flush with concurrent push
      for (int i = 0; i < 17; i++) push(8'h70 + 8'(i));
      rd(A_STATUS, 8'hD0, "fl_ovf_full");
      flush_with_push(8'h99);
      rd(A_STATUS, 8'hA0, "fl_keeps_ovf");
      wr(A_CTRL, 8'h04);
      rd(A_STATUS, 8'h20, "fl_ovf_cleared");
      for (int i = 1; i <= 5; i++) push(8'h80 + 8'(i));
      rd(A_STATUS, 8'h05, "fl_hold5");
      flush_with_push(8'h9A);
      rd(A_STATUS, 8'h20, "fl_status");

      // Peak
      rd(A_PEAK, pk(8'hAA), "peak_hist");
      push(8'h05); push(8'hF0); push(8'h30);
      rd(A_PEAK, pk(8'hF0), "peak_max");
      rd(A_PEAK, 8'h00,     "peak_cleared");
      bus.port_id = A_PEAK;
      tick();
      expect_val(K_IN, 8'h00, "peak_seed_read");
      bus.read_strobe = 1'b1;
      sample_valid    = 1'b1;
      sample_data     = 8'h22;
      tick();
      bus.read_strobe = 1'b0;
      sample_valid    = 1'b0;
      rd(A_PEAK, pk(8'h22), "peak_seeded");
      wr(A_CTRL, 8'h02);

      // THRESH=0 behaves as 1, then reset mid-push
      wr(A_THRESH, 8'd0);
      wr(A_CTRL, 8'h01);
      push(8'h33);
      tick();
      bus.port_id = A_DATA;
      tick();
      probe(K_IN,  8'h33, "pre_rst_in_port");
      probe(K_IRQ, 8'h01, "thresh0_irq");
      sample_valid = 1'b1;
      sample_data  = 8'h44;
      reset_n      = 1'b0;
      probe(K_IN,  8'h00, "midrst_in_port");
      probe(K_IRQ, 8'h00, "midrst_interrupt");
      sample_valid = 1'b0;
      reset_n      = 1'b1;
      tick();
      rd(A_STATUS, 8'h20, "midrst_status");
      probe(K_RDY, 8'h01, "midrst_ready");

      tick();
      done = 1'b1;
   end
endmodule
